// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word-organised RAM with byte-lane writes, 1-cycle read latency,
// a post-reset clear sequencer and a lane/alignment checker on incoming requests.
module data_sram_resp #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nxt;
  logic              init_done_nxt;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              req_ok;
  logic              wr_req;
  logic              clr_wr;
  logic              lanes_legal;
  logic              unused_addr_hi;

  // Upper address bits alias onto the same words; only the word index and byte offset matter.
  assign idx            = data_sram_addr[ADDR_W+1:2];
  assign off            = data_sram_addr[1:0];
  assign unused_addr_hi = ^data_sram_addr[31:ADDR_W+2];

  assign req_ok = (state == ST_READY) && data_sram_en;
  assign wr_req = req_ok && (data_sram_we != 4'b0000);
  assign clr_wr = (state == ST_CLEAR);

  // Legal lane patterns are naturally aligned byte, halfword and word accesses.
  always_comb begin
    lanes_legal = 1'b0;
    case (data_sram_we)
      4'b0000: lanes_legal = 1'b1;
      4'b0001,
      4'b0010,
      4'b0100,
      4'b1000: lanes_legal = (data_sram_we == (4'b0001 << off));
      4'b0011: lanes_legal = (off == 2'b00);
      4'b1100: lanes_legal = (off == 2'b10);
      4'b1111: lanes_legal = (off == 2'b00);
      default: lanes_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    clr_ptr_nxt   = clr_ptr;
    init_done_nxt = init_done;
    case (state)
      ST_CLEAR: begin
        if (&clr_ptr) begin
          state_nxt     = ST_READY;
          init_done_nxt = 1'b1;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      ST_READY: begin
        state_nxt = ST_READY;
      end
      default: begin
        state_nxt = RST_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= RST_STATE;
      clr_ptr         <= '0;
      init_done       <= !CLEAR_ON_RESET;
      data_sram_rdata <= '0;
      addr_err        <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_ptr   <= clr_ptr_nxt;
      init_done <= init_done_nxt;
      addr_err  <= req_ok && !lanes_legal;
      // Writes return the pre-write word (read-first).
      if (req_ok) begin
        data_sram_rdata <= mem[idx];
      end
    end
  end

  // The array itself has no reset; the clear sequencer owns zeroing it.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_ptr] <= '0;
    end else if (wr_req) begin
      for (int k = 0; k < 4; k++) begin
        if (data_sram_we[k]) begin
          mem[idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed and random requests scored against a behavioural model.
module tb_data_sram_resp;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        init_done;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  // Each entry: {init_done, addr_err, rdata} expected after one clock edge.
  logic [33:0] exp_q[$];

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  int          m_edges;

  data_sram_resp #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .init_done       (init_done),
    .addr_err        (addr_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Aligned access of 1, 2 or 4 bytes starting at the byte offset; empty mask is a read.
  function automatic bit legal_lanes(input logic [3:0] we, input int off);
    int n;
    n = $countones(we);
    if (n == 0) return 1'b1;
    if (n != 1 && n != 2 && n != 4) return 1'b0;
    if (off % n != 0) return 1'b0;
    return we == 4'(((1 << n) - 1) << off);
  endfunction

  // Driver: applies one cycle of inputs and pushes the expected post-edge outputs.
  task automatic cycle(input logic rst_v, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic err;
    logic init;
    int   idx;
    @(negedge clk);
    resetn          = rst_v;
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    err  = 1'b0;
    init = 1'b0;
    if (!rst_v) begin
      m_edges = 0;
      m_rdata = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      if (m_edges >= DEPTH && en) begin
        idx     = int'((addr >> 2) % DEPTH);
        m_rdata = m_mem[idx];
        for (int k = 0; k < 4; k++)
          if (we[k]) m_mem[idx][8*k +: 8] = wd[8*k +: 8];
        err = !legal_lanes(we, int'(addr[1:0]));
      end
      m_edges++;
      init = (m_edges >= DEPTH);
    end
    exp_q.push_back({init, err, m_rdata});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Scoreboard monitor: one expectation per edge, sampled just after the edge.
  always @(posedge clk) begin
    logic [33:0] e;
    if (exp_q.size() != 0) begin
      #1;
      e = exp_q.pop_front();
      check("rdata", data_sram_rdata, e[31:0]);
      check("addr_err", {31'b0, addr_err}, {31'b0, e[32]});
      check("init_done", {31'b0, init_done}, {31'b0, e[33]});
    end
  end

  initial begin
    logic [3:0] we_tab [9];
    logic [3:0] we_r;
    we_tab = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hc, 4'hf, 4'h6};
    resetn = 1'b0; data_sram_en = 1'b0; data_sram_we = '0;
    data_sram_addr = '0; data_sram_wdata = '0;
    m_rdata = '0; m_edges = 0;

    repeat (3) cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // T1: clear after reset release, then any word reads as zero
    idle(DEPTH);
    cycle(1'b1, 1'b1, 4'h0, $urandom, 32'h0);

    // T2: aliasing of upper address bits
    cycle(1'b1, 1'b1, 4'hf, 32'h1c00_0010, 32'hdead_beef);
    cycle(1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
    idle(1);

    // T3: partial lane writes
    cycle(1'b1, 1'b1, 4'b0100, 32'h12, 32'h5a5a_5a5a);
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    cycle(1'b1, 1'b1, 4'b1100, 32'h12, 32'h1234_1234);
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);

    // T4: read-first on writes
    cycle(1'b1, 1'b1, 4'hf, 32'h10, 32'h1111_1111);
    cycle(1'b1, 1'b1, 4'hf, 32'h10, 32'h2222_2222);
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);

    // T5: lane/alignment errors are single-cycle and report-only
    cycle(1'b1, 1'b1, 4'hf, 32'h13, 32'hcafe_f00d);
    idle(1);
    cycle(1'b1, 1'b1, 4'b0011, 32'h12, 32'h0000_7777);
    cycle(1'b1, 1'b1, 4'b0010, 32'h11, 32'h0000_9900);
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);

    // Random traffic over a small index window so reads hit earlier writes
    for (int i = 0; i < 400; i++) begin
      we_r = we_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) we_r = 4'($urandom_range(0, 15));
      cycle(1'b1, $urandom_range(0, 3) != 0, we_r,
            {$urandom_range(0, 1023) << 14, 10'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
            $urandom);
    end

    // T6: reset from READY, then again mid-clear
    cycle(1'b1, 1'b1, 4'hf, 32'h10, 32'h5555_aaaa);
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rst_rdata_now", data_sram_rdata, 32'h0);
    check("rst_init_now", {31'b0, init_done}, 32'h0);
    idle(500);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("midclr_init_now", {31'b0, init_done}, 32'h0);
    cycle(1'b1, 1'b1, 4'hf, 32'h10, 32'h7777_7777);
    idle(DEPTH - 1);
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    idle(2);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
